adder_operand_loader: RTL and testbench

ADDER_OPERAND_LOADER -- requirements
Module: adder_operand_loader

---
 rtl/adder_operand_loader.sv | 115 +++++++++++
 tb/tb_adder_operand_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_operand_loader.sv
// rtl/adder_operand_loader.sv - byte-serial operand loader and result unloader for a W-bit adder
module adder_operand_loader #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic         op_valid,
  input  logic [W:0]   sum_in,
  input  logic         sum_valid,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);
  localparam int NB = W / 8;
  localparam int NR = (W + 8) / 8;
  localparam int CW = $clog2(NR);
  localparam logic [CW-1:0] NB_LAST = CW'(NB - 1);
  localparam logic [CW-1:0] NR_LAST = CW'(NR - 1);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, ISSUE, WAIT, SEND} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [W:0]      result;
  logic [8*NR-1:0] result_ext;
  logic            in_fire, out_fire;

  assign in_fire    = in_valid && in_ready && ena;
  assign out_fire   = out_valid && out_ready && ena;
  // Carry-out sits alone in the top result byte; the rest of that byte reads as zero.
  assign result_ext = {{(8*NR-W-1){1'b0}}, result};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_A;
      cnt   <= '0;
    end else if (ena) begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      LOAD_A: if (in_fire) begin
        if (cnt == NB_LAST) begin
          state_next = LOAD_B;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      LOAD_B: if (in_fire) begin
        if (cnt == NB_LAST) begin
          state_next = ISSUE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: if (sum_valid) state_next = SEND;
      SEND: if (out_fire) begin
        if (cnt == NR_LAST) begin
          state_next = LOAD_A;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = LOAD_A;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
    end else if (ena) begin
      for (int k = 0; k < NB; k++) begin
        if (in_fire && cnt == CW'(k)) begin
          if (state == LOAD_A) op_a[8*k +: 8] <= in_data;
          if (state == LOAD_B) op_b[8*k +: 8] <= in_data;
        end
      end
      if (state == WAIT && sum_valid) result <= sum_in;
    end
  end

  always_comb begin
    in_ready  = (state == LOAD_A) || (state == LOAD_B);
    op_valid  = (state == ISSUE) && ena;
    out_valid = (state == SEND);
    busy      = !((state == LOAD_A) && (cnt == '0));
    out_data  = 8'h00;
    if (state == SEND) begin
      for (int j = 0; j < NR; j++) begin
        if (cnt == CW'(j)) out_data = result_ext[8*j +: 8];
      end
    end
  end
endmodule

// File: tb/tb_adder_operand_loader.sv
// tb/tb_adder_operand_loader.sv - randomized self-checking bench for adder_operand_loader
module tb_adder_operand_loader;
  localparam int W  = 16;
  localparam int NB = 2;
  localparam int NR = 3;
  localparam int P_LA = 0, P_LB = 1, P_IS = 2, P_WT = 3, P_SD = 4;

  logic         clk, rst, ena;
  logic [7:0]   in_data;
  logic         in_valid, in_ready;
  logic [W-1:0] op_a, op_b;
  logic         op_valid;
  logic [W:0]   sum_in;
  logic         sum_valid;
  logic [7:0]   out_data;
  logic         out_valid, out_ready, busy;

  adder_operand_loader #(.W(W)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .sum_in(sum_in), .sum_valid(sum_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase/byte index, operands and result as plain integers.
  int           m_phase, m_idx;
  logic [W-1:0] m_a, m_b;
  logic [W:0]   m_res;
  logic [7:0]   got[$];
  int           op_pulses;

  function automatic logic [W-1:0] put_byte(input logic [W-1:0] v, input int i, input logic [7:0] b);
    logic [W-1:0] mask;
    mask = W'(16'hff) << (8 * i);
    return (v & ~mask) | (W'(b) << (8 * i));
  endfunction

  task automatic m_reset();
    m_phase = P_LA;
    m_idx   = 0;
    m_a     = '0;
    m_b     = '0;
    m_res   = '0;
  endtask

  initial begin
    m_reset();
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("in_ready", 32'(in_ready), 32'(m_phase == P_LA || m_phase == P_LB));
      check("op_valid", 32'(op_valid), 32'(m_phase == P_IS && ena));
      check("out_valid", 32'(out_valid), 32'(m_phase == P_SD));
      check("out_data", 32'(out_data),
            32'((m_phase == P_SD) ? 8'(24'(m_res) >> (8 * m_idx)) : 8'h00));
      check("busy", 32'(busy), 32'(!(m_phase == P_LA && m_idx == 0)));
      check("op_a", 32'(op_a), 32'(m_a));
      check("op_b", 32'(op_b), 32'(m_b));
      if (out_valid && out_ready && ena && !rst) got.push_back(out_data);
      if (op_valid) op_pulses++;
      if (rst) begin
        m_reset();
      end else if (ena) begin
        if ((m_phase == P_LA || m_phase == P_LB) && in_valid) begin
          if (m_phase == P_LA) m_a = put_byte(m_a, m_idx, in_data);
          else                 m_b = put_byte(m_b, m_idx, in_data);
          if (m_idx == NB - 1) begin
            m_phase = m_phase + 1;
            m_idx   = 0;
          end else begin
            m_idx++;
          end
        end else if (m_phase == P_IS) begin
          m_phase = P_WT;
        end else if (m_phase == P_WT && sum_valid) begin
          m_res   = sum_in;
          m_phase = P_SD;
          m_idx   = 0;
        end else if (m_phase == P_SD && out_ready) begin
          if (m_idx == NR - 1) begin
            m_phase = P_LA;
            m_idx   = 0;
          end else begin
            m_idx++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd_ena);
    int  n;
    bit  acc;
    repeat ($urandom_range(0, 2)) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    for (n = 0; n < 50; n++) begin
      if (rnd_ena) ena = ($urandom_range(0, 4) != 0);
      acc = in_ready && ena;
      tick();
      if (acc) break;
    end
    if (n >= 50) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    ena      = 1'b1;
  endtask

  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] s,
                         input logic [23:0] exp, input bit early, input bit noise,
                         input int stall, input bit rnd_ena, input bit freeze);
    int n, stalled;
    got.delete();
    op_pulses = 0;
    for (int k = 0; k < NB; k++) send_byte(a[8*k +: 8], rnd_ena);
    send_byte(b[7:0], rnd_ena);
    if (freeze) begin
      // Caller reset first, so op_b's upper byte is known to be zero here.
      ena      = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      repeat (4) begin
        tick();
        check("freeze_op_b", 32'(op_b), 32'({8'h00, b[7:0]}));
        check("freeze_op_valid", 32'(op_valid), 32'd0);
        check("freeze_in_ready", 32'(in_ready), 32'd1);
      end
      in_valid = 1'b0;
      ena      = 1'b1;
    end
    for (int k = 1; k < NB; k++) send_byte(b[8*k +: 8], rnd_ena);
    ena = 1'b1;
    #1;
    check("issue_op_a", 32'(op_a), 32'(a));
    check("issue_op_b", 32'(op_b), 32'(b));
    check("issue_op_valid", 32'(op_valid), 32'd1);
    if (noise) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
    end
    if (early) begin
      sum_valid = 1'b1;
      sum_in    = 17'($urandom);
    end
    tick();
    sum_valid = 1'b0;
    repeat ($urandom_range(0, 3)) begin
      if (noise) in_data = 8'($urandom);
      if (rnd_ena) ena = ($urandom_range(0, 3) != 0);
      tick();
    end
    ena       = 1'b1;
    sum_valid = 1'b1;
    sum_in    = s;
    tick();
    sum_valid = 1'b0;
    stalled   = 0;
    for (n = 0; n < 300; n++) begin
      if (got.size() >= NR) break;
      if (stall > 0 && got.size() == 1 && stalled < stall) begin
        out_ready = 1'b0;
        ena       = 1'b1;
        tick();
        stalled++;
        check("stall_out_data", 32'(out_data), 32'(exp[15:8]));
        check("stall_out_valid", 32'(out_valid), 32'd1);
      end else begin
        out_ready = ($urandom_range(0, 2) != 0);
        if (rnd_ena) ena = ($urandom_range(0, 4) != 0);
        if (noise) in_data = 8'($urandom);
        tick();
      end
    end
    if (n >= 300) check("drain_timeout", 32'd0, 32'd1);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    ena       = 1'b1;
    check("byte_count", 32'(got.size()), 32'(NR));
    for (int j = 0; j < NR; j++) begin
      if (j < got.size()) check("out_byte", 32'(got[j]), 32'(exp[8*j +: 8]));
    end
    check("op_pulses", 32'(op_pulses), 32'd1);
    check("done_busy", 32'(busy), 32'd0);
    check("done_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W:0]   rs;
    rst = 1'b1; ena = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    sum_valid = 1'b0; sum_in = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_a", 32'(op_a), 32'd0);
    rst = 1'b0;
    ena = 1'b1;

    run_txn(16'h1234, 16'h4321, 17'h05555, 24'h005555, 0, 0, 0, 0, 0);
    run_txn(16'hFFFF, 16'h0001, 17'h10000, 24'h010000, 0, 0, 0, 0, 0);
    run_txn(16'h1234, 16'h4321, 17'h05555, 24'h005555, 0, 0, 5, 0, 0);

    // Partial load discarded by reset.
    for (int k = 0; k < 3; k++) send_byte(8'($urandom), 0);
    rst = 1'b1; tick(); rst = 1'b0;
    run_txn(16'h1234, 16'h4321, 17'h05555, 24'h005555, 0, 0, 0, 0, 0);

    rst = 1'b1; tick(); rst = 1'b0;
    run_txn(16'h1234, 16'h4321, 17'h05555, 24'h005555, 0, 0, 0, 0, 1);

    run_txn(16'h1234, 16'h4321, 17'h05555, 24'h005555, 1, 1, 0, 0, 0);

    // Reset while waiting for the adder.
    for (int k = 0; k < 2 * NB; k++) send_byte(8'($urandom), 0);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("midwait_op_a", 32'(op_a), 32'd0);
    check("midwait_busy", 32'(busy), 32'd0);
    run_txn(16'hA5C3, 16'h0F0F, 17'h0B4D2, 24'h00B4D2, 0, 0, 0, 0, 0);

    repeat (25) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = {1'b0, ra} + {1'b0, rb};
      run_txn(ra, rb, rs, 24'(rs), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 4)) : 0, 1, 0);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
